// File: rtl/alarm_pkg.sv
// Shared constants for the LCD-clock alarm scheduler: time field limits and widths,
// FSM state codes shown on the LCD, the default alarm time and the button bundle.
package alarm_pkg;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  localparam int HOUR_W = $clog2(HOUR_MAX + 1);
  localparam int MIN_W  = $clog2(MIN_MAX + 1);
  localparam int SEC_W  = $clog2(SEC_MAX + 1);

  localparam logic [HOUR_W-1:0] DEFAULT_HOUR = HOUR_W'(7);
  localparam logic [MIN_W-1:0]  DEFAULT_MIN  = '0;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_DISARMED = 3'd0;
  localparam logic [STATE_W-1:0] ST_ARMED    = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETTING  = 3'd2;
  localparam logic [STATE_W-1:0] ST_RINGING  = 3'd3;
  localparam logic [STATE_W-1:0] ST_SNOOZE   = 3'd4;

  // Bit order matches sw[3:0].
  typedef struct packed {
    logic stop;
    logic min_up;
    logic hour_arm;
    logic set;
  } btn_t;

  function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] h);
    return (h == HOUR_W'(HOUR_MAX)) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
    return (m == MIN_W'(MIN_MAX)) ? '0 : m + 1'b1;
  endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the clock/button side and the alarm scheduler.
// The master side supplies buttons and current time; the slave side is alarm_ctrl.
interface alarm_ctrl_if;
  import alarm_pkg::*;

  logic [3:0]         sw;
  logic [SEC_W-1:0]   sec;
  logic [MIN_W-1:0]   min;
  logic [HOUR_W-1:0]  hour;
  logic [HOUR_W-1:0]  alarm_hour;
  logic [MIN_W-1:0]   alarm_min;
  logic [STATE_W-1:0] alarm_state;
  logic               enable;

  modport master (
    output sw, sec, min, hour,
    input  alarm_hour, alarm_min, alarm_state, enable
  );

  modport slave (
    input  sw, sec, min, hour,
    output alarm_hour, alarm_min, alarm_state, enable
  );

endinterface

// File: rtl/alarm_ctrl_btn_edge.sv
// Button conditioning: SYNC_STAGES-flop synchronizer followed by a rising-edge
// detector producing a one-cycle pulse in the cycle after the synced edge lands.
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm scheduler: button decode, alarm time storage, time compare and ring/snooze FSM.
// Optional snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5,
  parameter int SYNC_STAGES    = 2
) (
  input  logic          clk,
  input  logic          reset,
  alarm_ctrl_if.slave   bus
);

  localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);

  logic [3:0] pulse;
  btn_t       btn;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn_edge (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (bus.sw[i]),
      .pulse_o(pulse[i])
    );
  end

  assign btn = btn_t'(pulse);

  logic [SEC_W-1:0]   sec_q;
  logic               tick_en_q;
  logic               sec_tick;
  logic               trigger;
  logic [STATE_W-1:0] state_q, state_d;
  logic [HOUR_W-1:0]  alarm_hour_q, alarm_hour_d;
  logic [MIN_W-1:0]   alarm_min_q, alarm_min_d;
  logic [7:0]         ring_cnt_q, ring_cnt_d;
  logic               enable_q;
`ifdef ALARM_SNOOZE_EN
  localparam logic [11:0] SNZ_LAST = 12'(SNOOZE_MIN * 60 - 1);
  logic [11:0]        snz_cnt_q, snz_cnt_d;
`endif

  // tick_en_q masks the first post-reset cycle, when sec_q still holds its reset value.
  assign sec_tick = tick_en_q && (bus.sec != sec_q);
  assign trigger  = sec_tick && (bus.sec == '0) &&
                    (bus.hour == alarm_hour_q) && (bus.min == alarm_min_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    ring_cnt_d   = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d    = snz_cnt_q;
`endif
    case (state_q)
      ST_DISARMED: begin
        if (btn.set)           state_d = ST_SETTING;
        else if (btn.hour_arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (btn.set)           state_d = ST_SETTING;
        else if (btn.hour_arm) state_d = ST_DISARMED;
        else if (trigger)      state_d = ST_RINGING;
      end
      ST_SETTING: begin
        if (btn.set) begin
          state_d = ST_ARMED;
        end else begin
          if (btn.hour_arm) alarm_hour_d = inc_hour(alarm_hour_q);
          if (btn.min_up)   alarm_min_d  = inc_min(alarm_min_q);
        end
      end
      ST_RINGING: begin
        if (btn.stop) begin
`ifdef ALARM_SNOOZE_EN
          state_d = ST_SNOOZE;
`else
          state_d = ST_ARMED;
`endif
        end else if (sec_tick) begin
          if (ring_cnt_q == RING_LAST) state_d = ST_ARMED;
          else                         ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (btn.stop) begin
          state_d = ST_ARMED;
        end else if (sec_tick) begin
          if (snz_cnt_q == SNZ_LAST) state_d = ST_RINGING;
          else                       snz_cnt_d = snz_cnt_q + 12'd1;
        end
      end
`endif
      default: state_d = ST_DISARMED;
    endcase

    // Counters always restart from zero in whichever state is entered next.
    if (state_d != state_q) begin
      ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q        <= '0;
      tick_en_q    <= 1'b0;
      state_q      <= ST_DISARMED;
      alarm_hour_q <= DEFAULT_HOUR;
      alarm_min_q  <= DEFAULT_MIN;
      ring_cnt_q   <= '0;
      enable_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q    <= '0;
`endif
    end else begin
      sec_q        <= bus.sec;
      tick_en_q    <= 1'b1;
      state_q      <= state_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      ring_cnt_q   <= ring_cnt_d;
      enable_q     <= (state_q == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q    <= snz_cnt_d;
`endif
    end
  end

  assign bus.alarm_hour  = alarm_hour_q;
  assign bus.alarm_min   = alarm_min_q;
  assign bus.alarm_state = state_q;
  assign bus.enable      = enable_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus a randomized action
// sequence, all compared against a second-by-second behavioural model of the alarm.
module tb_alarm_ctrl;
  import alarm_pkg::*;

  localparam int RING_TIMEOUT_S = 60;
  localparam int SNOOZE_MIN     = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alarm_ctrl_if bus ();

  alarm_ctrl #(
    .RING_TIMEOUT_S(RING_TIMEOUT_S),
    .SNOOZE_MIN    (SNOOZE_MIN),
    .SYNC_STAGES   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef enum {M_DIS, M_ARM, M_SET, M_RING, M_SNZ} mstate_t;

  mstate_t m_state;
  int m_ah, m_am, m_ring, m_snz;
  int cur_h, cur_m, cur_s;
  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [2:0] code_of(input mstate_t s);
    case (s)
      M_DIS:   return ST_DISARMED;
      M_ARM:   return ST_ARMED;
      M_SET:   return ST_SETTING;
      M_RING:  return ST_RINGING;
      default: return ST_SNOOZE;
    endcase
  endfunction

  function automatic logic [14:0] exp_vec();
    return {code_of(m_state), 5'(m_ah), 6'(m_am), m_state == M_RING};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {bus.alarm_state, bus.alarm_hour, bus.alarm_min, bus.enable};
  endfunction

  function automatic string fmt(input logic [14:0] v);
    return $sformatf("state=%0d alarm=%0d:%0d en=%b", v[14:12], v[11:7], v[6:1], v[0]);
  endfunction

  // Model: one button press applied in full
  task automatic model_press(input logic [3:0] m);
    case (m_state)
      M_DIS: if (m[0]) m_state = M_SET; else if (m[1]) m_state = M_ARM;
      M_ARM: if (m[0]) m_state = M_SET; else if (m[1]) m_state = M_DIS;
      M_SET: begin
        if (m[0]) m_state = M_ARM;
        else begin
          if (m[1]) m_ah = (m_ah + 1) % 24;
          if (m[2]) m_am = (m_am + 1) % 60;
        end
      end
      M_RING: begin
        if (m[3]) begin
`ifdef ALARM_SNOOZE_EN
          m_state = M_SNZ;
          m_snz   = 0;
`else
          m_state = M_ARM;
`endif
        end
      end
      default: if (m[3]) m_state = M_ARM;
    endcase
  endtask

  // Model: the clock display changes to h:m:s
  task automatic model_time(input int h, input int m, input int s);
    bit tk;
    tk = (s != cur_s);
    cur_h = h; cur_m = m; cur_s = s;
    if (tk) begin
      case (m_state)
        M_ARM: if (s == 0 && h == m_ah && m == m_am) begin m_state = M_RING; m_ring = 0; end
        M_RING: begin m_ring++; if (m_ring == RING_TIMEOUT_S) m_state = M_ARM; end
        M_SNZ: begin
          m_snz++;
          if (m_snz == SNOOZE_MIN * 60) begin m_state = M_RING; m_ring = 0; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk); bus.sw = m;
    repeat (4) @(negedge clk);
    bus.sw = '0;
    repeat (4) @(negedge clk);
    model_press(m);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    @(negedge clk);
    bus.hour = 5'(h); bus.min = 6'(m); bus.sec = 6'(s);
    repeat (3) @(negedge clk);
    model_time(h, m, s);
  endtask

  task automatic tick();
    int t;
    t = (cur_h * 3600 + cur_m * 60 + cur_s + 1) % 86400;
    set_time(t / 3600, (t / 60) % 60, t % 60);
  endtask

  task automatic test_reset();
    bus.sw = '0; bus.hour = 5'd10; bus.min = 6'd0; bus.sec = 6'd30;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (dut_vec() !== {ST_DISARMED, 5'd7, 6'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_hold: got %s, expected %s", fmt(dut_vec()), fmt({ST_DISARMED, 5'd7, 6'd0, 1'b0}));
    end
    reset = 1'b1;
    m_state = M_DIS; m_ah = 7; m_am = 0; m_ring = 0; m_snz = 0;
    cur_h = 10; cur_m = 0; cur_s = 30;
    repeat (3) @(negedge clk);
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL reset_release: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
  endtask

  task automatic test_arm();
    press(4'b0010);
    tests_run++;
    if (dut_vec() !== {ST_ARMED, 5'd7, 6'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL arm: got %s, expected %s", fmt(dut_vec()), fmt({ST_ARMED, 5'd7, 6'd0, 1'b0}));
    end
  endtask

  task automatic test_set_alarm();
    press(4'b0001);
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL enter_setting: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
    repeat (3) press(4'b0010);
    repeat (61) press(4'b0100);
    press(4'b0001);
    tests_run++;
    if (dut_vec() !== {ST_ARMED, 5'd10, 6'd1, 1'b0} || exp_vec() !== {ST_ARMED, 5'd10, 6'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL set_10_01: got %s, expected %s", fmt(dut_vec()), fmt({ST_ARMED, 5'd10, 6'd1, 1'b0}));
    end
  endtask

  task automatic test_wrap();
    press(4'b0001);
    repeat (13) press(4'b0010);
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.alarm_hour !== 5'd23) begin
      tests_failed++;
      $display("FAIL hour_23: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
    press(4'b0010);
    repeat (58) press(4'b0100);
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.alarm_hour !== 5'd0 || bus.alarm_min !== 6'd59) begin
      tests_failed++;
      $display("FAIL hour_wrap_min_59: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
    press(4'b0100);
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.alarm_min !== 6'd0) begin
      tests_failed++;
      $display("FAIL min_wrap: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
    press(4'b0110);
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL hour_min_same_cycle: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
    repeat (9) press(4'b0010);
    press(4'b0001);
    tests_run++;
    if (dut_vec() !== {ST_ARMED, 5'd10, 6'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL restore_10_01: got %s, expected %s", fmt(dut_vec()), fmt({ST_ARMED, 5'd10, 6'd1, 1'b0}));
    end
  endtask

  task automatic test_ring();
    set_time(10, 0, 58);
    set_time(10, 0, 59);
    @(negedge clk);
    bus.min = 6'd1; bus.sec = 6'd0;
    @(posedge clk); @(posedge clk); #1;
    tests_run++;
    if (bus.enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL ring_latency: got en=%b, expected en=1", bus.enable);
    end
    model_time(10, 1, 0);
    repeat (RING_TIMEOUT_S - 1) tick();
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL ring_before_timeout: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
    tick();
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.enable !== 1'b0 || bus.alarm_state !== ST_ARMED) begin
      tests_failed++;
      $display("FAIL ring_timeout: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
  endtask

  task automatic test_stop();
    set_time(10, 0, 59);
    set_time(10, 1, 0);
    press(4'b0111);
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL ring_ignores_sw012: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
    press(4'b1000);
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL stop_in_ring: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
`ifdef ALARM_SNOOZE_EN
    press(4'b0001);
    repeat (SNOOZE_MIN * 60 - 1) tick();
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.alarm_state !== ST_SNOOZE) begin
      tests_failed++;
      $display("FAIL snooze_hold: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
    tick();
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL snooze_expire: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
    press(4'b1000);
    press(4'b1000);
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.alarm_state !== ST_ARMED) begin
      tests_failed++;
      $display("FAIL snooze_cancel: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
`endif
  endtask

  task automatic test_time_jump();
    set_time(10, 1, 30);
    set_time(10, 0, 59);
    set_time(10, 1, 1);
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL time_jump: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
  endtask

  task automatic test_coincident();
    bit saw_en;
    set_time(10, 0, 59);
    saw_en = 1'b0;
    @(negedge clk); bus.sw = 4'b0001;
    @(negedge clk);
    @(negedge clk); bus.min = 6'd1; bus.sec = 6'd0;
    @(negedge clk); saw_en |= bus.enable;
    @(negedge clk); saw_en |= bus.enable; bus.sw = '0;
    repeat (5) begin @(negedge clk); saw_en |= bus.enable; end
    model_press(4'b0001);
    model_time(10, 1, 0);
    tests_run++;
    if (dut_vec() !== exp_vec() || saw_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL set_beats_trigger: got %s seen_en=%b, expected %s", fmt(dut_vec()), saw_en, fmt(exp_vec()));
    end
    press(4'b0001);
  endtask

  task automatic test_random();
    int r;
    set_time(10, 0, 50);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      tick();
      else if (r < 9) press(4'($urandom_range(1, 15)));
      else            set_time(m_ah, m_am, $urandom_range(0, 59));
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_step_%0d: got %s, expected %s", i, fmt(dut_vec()), fmt(exp_vec()));
      end
    end
  endtask

  task automatic test_reset_ring();
    int t;
    for (int k = 0; k < 4 && m_state != M_ARM; k++) begin
      if (m_state == M_SET)      press(4'b0001);
      else if (m_state == M_DIS) press(4'b0010);
      else                       press(4'b1000);
    end
    t = (m_ah * 3600 + m_am * 60 + 86399) % 86400;
    set_time(t / 3600, (t / 60) % 60, t % 60);
    tick();
    tests_run++;
    if (dut_vec() !== exp_vec() || bus.enable !== 1'b1) begin
      tests_failed++;
      $display("FAIL ring_before_reset: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (dut_vec() !== {ST_DISARMED, 5'd7, 6'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid_ring: got %s, expected %s", fmt(dut_vec()), fmt({ST_DISARMED, 5'd7, 6'd0, 1'b0}));
    end
    m_state = M_DIS; m_ah = 7; m_am = 0; m_ring = 0; m_snz = 0;
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL after_reset_release: got %s, expected %s", fmt(dut_vec()), fmt(exp_vec()));
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_set_alarm();
    test_wrap();
    test_ring();
    test_stop();
    test_time_jump();
    test_coincident();
    test_random();
    test_reset_ring();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
